// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter ownership state: free, or held by one requester under lock.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // Requester identifiers, used for the round-robin history bit.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Default geometry.
  localparam int DEFAULT_ADDR_WIDTH   = 16;
  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_LOCK_TIMEOUT = 16;

  // Bits needed to hold a count from 0 up to and including max_count.
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_port
// Description : Per-requester read-return register. Captures memory read data
//               on a read grant and pulses rvalid for one cycle afterwards.
//               rdata holds until the next read by the same requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_port
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_grant,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Capture read data on a read grant; rvalid follows the grant by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_grant;
      if (rd_grant) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter for one single-port byte memory.
//               Round-robin between contending requesters, with a per-owner
//               lock for atomic read-modify-write sequences and an idle
//               timeout that forcibly releases an abandoned lock.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  // Port A (CPU)
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  // Port B (DMA / video fetch)
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  // Memory
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // A timeout of zero would release a lock before it could ever be used.
  localparam int EFF_TIMEOUT = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;
  localparam int TIMER_W     = count_width(EFF_TIMEOUT);
  // The owner is released on the edge where the idle count would reach
  // the timeout, so the last tolerated value is one below it.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(EFF_TIMEOUT - 1);

  arb_state_t          state;
  arb_state_t          state_next;
  logic                rr_last;
  logic                rr_last_next;
  logic [TIMER_W-1:0]  lock_timer;
  logic [TIMER_W-1:0]  lock_timer_next;

  logic                grant_a;
  logic                grant_b;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] wdata_hold;

  // Grant selection: owner-only under lock, otherwise round-robin on a tie.
  // Grants are suppressed while reset is asserted so no access leaks out.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      case (state)
        OWN_A: grant_a = a_req;
        OWN_B: grant_b = b_req;
        default: begin
          if (a_req && b_req) begin
            grant_a = (rr_last == REQ_B);
            grant_b = (rr_last == REQ_A);
          end else begin
            grant_a = a_req;
            grant_b = b_req;
          end
        end
      endcase
    end
  end

  // Lock FSM, idle timer and round-robin history next-state logic.
  always_comb begin
    state_next      = state;
    lock_timer_next = lock_timer;
    rr_last_next    = rr_last;

    if (grant_a) begin
      rr_last_next = REQ_A;
    end else if (grant_b) begin
      rr_last_next = REQ_B;
    end

    case (state)
      IDLE: begin
        lock_timer_next = '0;
        if (grant_a && a_lock) begin
          state_next = OWN_A;
        end else if (grant_b && b_lock) begin
          state_next = OWN_B;
        end
      end
      OWN_A: begin
        if (grant_a) begin
          lock_timer_next = '0;
          state_next      = a_lock ? OWN_A : IDLE;
        end else if (lock_timer >= TIMER_LAST) begin
          lock_timer_next = '0;
          state_next      = IDLE;
        end else begin
          lock_timer_next = lock_timer + 1'b1;
        end
      end
      OWN_B: begin
        if (grant_b) begin
          lock_timer_next = '0;
          state_next      = b_lock ? OWN_B : IDLE;
        end else if (lock_timer >= TIMER_LAST) begin
          lock_timer_next = '0;
          state_next      = IDLE;
        end else begin
          lock_timer_next = lock_timer + 1'b1;
        end
      end
      default: begin
        lock_timer_next = '0;
        state_next      = IDLE;
      end
    endcase
  end

  // State, timer and round-robin history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_last    <= REQ_B;
      lock_timer <= '0;
    end else begin
      state      <= state_next;
      rr_last    <= rr_last_next;
      lock_timer <= lock_timer_next;
    end
  end

  // Route the granted requester to memory; hold the last address and data
  // when idle so the memory bus does not toggle without an access.
  always_comb begin
    mem_read  = (grant_a & ~a_we) | (grant_b & ~b_we);
    mem_write = (grant_a &  a_we) | (grant_b &  b_we);
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (grant_a) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (grant_b) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Remember the most recently driven address and write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (grant_a || grant_b) begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  mem_arb_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_a (
    .clk       (clk),
    .reset     (reset),
    .rd_grant  (grant_a & ~a_we),
    .mem_rdata (mem_rdata),
    .rvalid    (a_rvalid),
    .rdata     (a_rdata)
  );

  mem_arb_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_b (
    .clk       (clk),
    .reset     (reset),
    .rd_grant  (grant_b & ~b_we),
    .mem_rdata (mem_rdata),
    .rvalid    (b_rvalid),
    .rdata     (b_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level model
//               predicts grants and memory contents; read results are queued
//               per port and matched by an independent return monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Physical memory seen by the DUT, and the model's own copy.
  logic [DW-1:0] phys_mem [0:65535];
  logic [DW-1:0] ref_mem  [0:65535];
  assign mem_rdata = phys_mem[mem_addr];
  always @(posedge clk) if (mem_write) phys_mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct { logic [DW-1:0] data; int due; } rd_exp_t;
  rd_exp_t qa[$];
  rd_exp_t qb[$];
  int cyc = 0;
  int owner = 0;        // 0 = nobody holds the lock, 1 = A, 2 = B
  int last_win = 1;     // 0 = A won last, 1 = B won last
  int idle_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] last_ra = '0, last_rb = '0;
  logic pg_a = 1'b0, pg_b = 1'b0, p_we = 1'b0, p_lock = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic seen_a = 1'b0, seen_b = 1'b0;

  // Predictor: decide who should be served this cycle and check the bus.
  always @(negedge clk) begin
    logic ea, eb;
    ea = 1'b0; eb = 1'b0;
    if (!reset) begin
      if (owner == 1) ea = a_req;
      else if (owner == 2) eb = b_req;
      else if (a_req && b_req) begin
        if (last_win == 1) ea = 1'b1; else eb = 1'b1;
      end else begin
        ea = a_req; eb = b_req;
      end
    end
    seen_a = a_gnt;
    seen_b = b_gnt;
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    pg_a = ea; pg_b = eb;
    p_we   = ea ? a_we    : b_we;
    p_lock = ea ? a_lock  : b_lock;
    p_addr = ea ? a_addr  : b_addr;
    p_wdata= ea ? a_wdata : b_wdata;
    if (ea || eb) begin
      chk("mem_addr", mem_addr, p_addr);
      chk("mem_wdata", mem_wdata, p_wdata);
      chk("mem_read", mem_read, !p_we);
      chk("mem_write", mem_write, p_we);
      if (!p_we) begin
        if (ea) qa.push_back('{data: ref_mem[p_addr], due: cyc + 1});
        else    qb.push_back('{data: ref_mem[p_addr], due: cyc + 1});
      end
    end else begin
      chk("mem_addr_hold", mem_addr, last_addr);
      chk("mem_wdata_hold", mem_wdata, last_wdata);
      chk("mem_read_idle", mem_read, 1'b0);
      chk("mem_write_idle", mem_write, 1'b0);
    end
  end

  // Model update on the clock edge: ownership, history, memory contents.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      owner = 0; last_win = 1; idle_cnt = 0;
      last_addr = '0; last_wdata = '0;
      last_ra = '0; last_rb = '0;
      qa.delete(); qb.delete();
    end else if (pg_a || pg_b) begin
      last_win = pg_a ? 0 : 1;
      last_addr = p_addr;
      last_wdata = p_wdata;
      if (p_we) ref_mem[p_addr] = p_wdata;
      owner = p_lock ? (pg_a ? 1 : 2) : 0;
      idle_cnt = 0;
    end else if (owner != 0) begin
      idle_cnt = idle_cnt + 1;
      if (idle_cnt >= LT) begin
        owner = 0;
        idle_cnt = 0;
      end
    end
  end

  // Return monitor: match rvalid/rdata against queued expectations.
  always @(negedge clk) begin
    logic ev;
    rd_exp_t e;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    chk("a_rvalid", a_rvalid, ev);
    if (ev) begin
      e = qa.pop_front();
      chk("a_rdata", a_rdata, e.data);
      last_ra = e.data;
    end else chk("a_rdata_hold", a_rdata, last_ra);
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    chk("b_rvalid", b_rvalid, ev);
    if (ev) begin
      e = qb.pop_front();
      chk("b_rdata", b_rdata, e.data);
      last_rb = e.data;
    end else chk("b_rdata_hold", b_rdata, last_rb);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[16'h0010] = 8'h5A;
    ref_mem[16'h0010]  = 8'h5A;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_rdata", a_rdata, 8'h00);
    chk("rst_b_rdata", b_rdata, 8'h00);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);

    // Single read.
    set_a(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    #1;
    chk("single_gnt", a_gnt, 1'b1);
    chk("single_mem_read", mem_read, 1'b1);
    chk("single_mem_addr", mem_addr, 16'h0010);
    tick();
    a_req = 1'b0;
    chk("single_rvalid", a_rvalid, 1'b1);
    chk("single_rdata", a_rdata, 8'h5A);
    tick();

    // Contention: both reading continuously.
    set_a(1'b1, 1'b0, 1'b0, 16'h0020, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 16'h0021, 8'h00);
    repeat (8) tick();
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // B writes, A reads the same address next cycle.
    set_b(1'b1, 1'b1, 1'b0, 16'h0200, 8'h33);
    tick();
    b_req = 1'b0;
    set_a(1'b1, 1'b0, 1'b0, 16'h0200, 8'h00);
    tick();
    a_req = 1'b0;
    chk("wr_rd_rdata", a_rdata, 8'h33);
    tick();

    // Locked read-modify-write holds B off.
    set_a(1'b1, 1'b0, 1'b1, 16'h0100, 8'h00);
    tick();
    set_b(1'b1, 1'b0, 1'b0, 16'h0005, 8'h00);
    set_a(1'b1, 1'b1, 1'b0, 16'h0100, 8'hC3);
    #1;
    chk("rmw_b_blocked", b_gnt, 1'b0);
    chk("rmw_a_write", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    #1;
    chk("rmw_b_after", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;

    // Lock abandoned by A: B waits out the timeout.
    set_a(1'b1, 1'b0, 1'b1, 16'h0101, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 16'h0006, 8'h00);
    tick();
    a_req = 1'b0;
    n = 0;
    while (n < 20) begin
      #1;
      if (b_gnt) break;
      tick();
      n++;
    end
    chk("timeout_idle_cycles", n, LT);
    tick();
    b_req = 1'b0;
    tick();

    // Reset in the cycle after a read grant.
    set_a(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    tick();
    a_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_rvalid", a_rvalid, 1'b0);
    chk("rstmid_rdata", a_rdata, 8'h00);
    set_a(1'b1, 1'b0, 1'b0, 16'h0011, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 16'h0012, 8'h00);
    #1;
    chk("rstmid_tie_a", a_gnt, 1'b1);
    chk("rstmid_tie_b", b_gnt, 1'b0);
    tick();
    a_req = 1'b0;
    tick();
    b_req = 1'b0;
    tick();

    // Randomized traffic with occasional locks and resets.
    for (int i = 0; i < 4000; i++) begin
      if (!a_req || seen_a) begin
        if ($urandom_range(0, 3) != 0)
          set_a(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                16'($urandom_range(0, 15)), 8'($urandom));
        else a_req = 1'b0;
      end
      if (!b_req || seen_b) begin
        if ($urandom_range(0, 3) != 0)
          set_b(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                16'($urandom_range(0, 15)), 8'($urandom));
        else b_req = 1'b0;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port byte memory (combinational read, write on clock edge) between port A (CPU) and port B (DMA/video fetch).
- One memory access per cycle, either read or write.
- Round-robin between contending requesters, plus a lock for atomic read-modify-write sequences.
- Read data is registered and returned one cycle after the grant.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory data width.
- LOCK_TIMEOUT, 16, idle cycles of a lock owner before the lock is forcibly released; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  A requests an access; held with a_addr/a_we/a_wdata/a_lock stable until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_lock  input  1  keep ownership after this access.
- a_addr  input  ADDR_WIDTH  access address.
- a_wdata  input  DATA_WIDTH  write data.
- a_gnt  output  1  access performed this cycle (combinational).
- a_rvalid  output  1  a_rdata valid, one cycle after a read grant.
- a_rdata  output  DATA_WIDTH  registered read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for port B.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory combinational read data.

Behaviour:
- Clocking: single clock; reset is synchronous, active-high.
- Reset values:
  - all gnt, rvalid, mem_read, mem_write = 0.
  - rdata = 0, mem_addr = 0, mem_wdata = 0.
  - state = IDLE, rr_last = B (A wins the first tie), lock timer = 0.
- Grant selection (combinational from req inputs and state):
  - IDLE: only one req -> grant it. Both -> grant the requester != rr_last.
  - OWN_A: only A may be granted; b_req waits. OWN_B: symmetric.
- Memory drive:
  - Granted requester's addr/wdata routed to mem_addr/mem_wdata.
  - mem_read = gnt & ~we; mem_write = gnt & we.
  - No grant: strobes 0; mem_addr/mem_wdata hold their last driven value (registered mux select) so no spurious toggling.
- Handshake: gnt is high for exactly the cycle the access happens; the requester may change inputs the following cycle. Back-to-back grants to the same requester are allowed every cycle when uncontended.
- Read return: on a read grant edge, mem_rdata is captured into x_rdata; x_rvalid = 1 the next cycle for one cycle. Write grants never raise rvalid. x_rdata holds until the next read by that requester.
- rr_last: updates to the granted requester on every grant edge.
- State transitions (on edge):
  - IDLE -> OWN_x when x granted with x_lock = 1.
  - OWN_x -> OWN_x when x granted with lock = 1; timer cleared.
  - OWN_x -> IDLE when x granted with lock = 0; this access still completes.
  - OWN_x -> IDLE when the timer reaches LOCK_TIMEOUT. The timer counts cycles in OWN_x without x_req, saturating, and clears on any x grant.
- Fairness: with both requesting continuously and no locks, grants alternate A,B,A,B.
- Reset mid-operation: pending rvalid is dropped, lock is released, rr_last returns to B.
- Reads of the same address written in the previous cycle return the new data, since the memory write lands on the grant edge.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, OWN_A, OWN_B), requester id constants (REQ_A = 0, REQ_B = 1), default widths.
- One natural sub-module, mem_arb_port: per-requester read-return register (rdata capture, rvalid pulse). Instantiated twice.
- Arbitration, lock FSM and timer stay in the top level.

Test Plan:
- Single read: preload mem[0x0010] = 0x5A; a_req=1, a_we=0, a_addr=0x0010 -> a_gnt=1 same cycle; mem_read=1, mem_addr=0x0010; next cycle a_rvalid=1, a_rdata=0x5A.
- Contention: both request reads continuously after reset -> grants A,B,A,B; each rvalid one cycle after its grant; never two grants in one cycle.
- Write then read: b writes 0x33 to 0x0200, then a reads 0x0200 the next cycle -> a_rdata=0x33; mem_write=1 only in the b grant cycle.
- Lock RMW: A reads 0x0100 with a_lock=1 while b_req is held -> B is not granted. A then writes 0x0100 with lock=0 -> state returns to IDLE; b_gnt on the following cycle.
- Lock timeout (LOCK_TIMEOUT=4): A locks then drops a_req while b_req=1 -> b_gnt is first asserted 4 idle cycles later, not earlier.
- Reset mid-read: assert reset in the cycle after a read grant -> a_rvalid=0, a_rdata=0, state IDLE, and the first post-reset tie goes to A.
